// File: rtl/trap_ctrl.sv
// Trap controller: takes exceptions and interrupts from EX, redirects fetch, handles MRET return and the trap CSRs.
// Build option: define TRAP_VECTORED_EN so interrupts target TVEC + 4*idx; otherwise every trap targets TVEC.
module trap_ctrl #(
  parameter int unsigned N_IRQ    = 8,
  parameter logic [31:0] TVEC_RST = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic             mret,
  input  logic             csr_we,
  input  logic [2:0]       csr_addr,
  input  logic [31:0]      csr_wdata,
  output logic [31:0]      csr_rdata,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             in_trap,
  output logic             double_fault
);

  localparam int unsigned IDX_W = 5;

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] ENTER   = 2'd1;
  localparam logic [1:0] HANDLER = 2'd2;
  localparam logic [1:0] RETURN  = 2'd3;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_MASK   = 3'd1;
  localparam logic [2:0] A_PEND   = 3'd2;
  localparam logic [2:0] A_SEPC   = 3'd3;
  localparam logic [2:0] A_SCAUSE = 3'd4;
  localparam logic [2:0] A_TVEC   = 3'd5;

  logic [1:0]       state_q, state_d;
  logic             ie_q, ie_d;
  logic             exl_q, exl_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] irq_q;
  logic [31:0]      sepc_q, sepc_d;
  logic [31:0]      scause_q, scause_d;
  logic [31:0]      tvec_q, tvec_d;
  logic             dfault_q, dfault_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] pend_w;
  logic [N_IRQ-1:0] taken_oh;
  logic [IDX_W-1:0] irq_idx;
  logic             irq_any;
  logic [31:0]      irq_tgt;

  // Edge detect and lowest-index-first interrupt selection
  always_comb begin : irq_pick
    rise    = irq_in & ~irq_q;
    elig    = pend_q & mask_q & {N_IRQ{ie_q & ~exl_q}};
    irq_any = |elig;
    irq_idx = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (elig[i]) irq_idx = IDX_W'(i);
    end
  end

  // Next state: software CSR writes first, hardware updates override them
  always_comb begin : next_state
    state_d       = state_q;
    ie_d          = ie_q;
    exl_d         = exl_q;
    mask_d        = mask_q;
    pend_w        = pend_q;
    sepc_d        = sepc_q;
    scause_d      = scause_q;
    tvec_d        = tvec_q;
    dfault_d      = dfault_q;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    taken_oh      = '0;
    irq_tgt       = '0;

    if (csr_we) begin
      case (csr_addr)
        A_STATUS: begin
          ie_d  = csr_wdata[0];
          exl_d = csr_wdata[1];
        end
        A_MASK:   mask_d   = csr_wdata[N_IRQ-1:0];
        A_PEND:   pend_w   = pend_q & ~csr_wdata[N_IRQ-1:0];
        A_SEPC:   sepc_d   = {csr_wdata[31:2], 2'b00};
        A_SCAUSE: scause_d = csr_wdata;
        A_TVEC:   tvec_d   = {csr_wdata[31:2], 2'b00};
        default:  ;
      endcase
    end

`ifdef TRAP_VECTORED_EN
    irq_tgt = tvec_d + (32'(irq_idx) << 2);
`else
    irq_tgt = tvec_d;
`endif

    case (state_q)
      RUN: begin
        if (ex_valid && (exc_valid || irq_any)) begin
          state_d    = ENTER;
          exl_d      = 1'b1;
          sepc_d     = ex_pc;
          redirect_d = 1'b1;
          if (exc_valid) begin
            scause_d      = {27'b0, exc_code};
            redirect_pc_d = tvec_d;
            dfault_d      = dfault_q | exl_q;
          end else begin
            scause_d      = {1'b1, 26'b0, irq_idx};
            taken_oh      = N_IRQ'(1) << irq_idx;
            redirect_pc_d = irq_tgt;
          end
        end
      end
      ENTER:   state_d = HANDLER;
      HANDLER: begin
        if (ex_valid && exc_valid) begin
          dfault_d = 1'b1;
        end else if (ex_valid && mret) begin
          state_d       = RETURN;
          exl_d         = 1'b0;
          redirect_d    = 1'b1;
          redirect_pc_d = sepc_d;
        end
      end
      RETURN:  state_d = RUN;
      default: state_d = RUN;
    endcase

    // A fresh edge re-arms a bit even if it is being taken or cleared this cycle
    pend_d = (pend_w & ~taken_oh) | rise;
  end

  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) begin
      state_q       <= RUN;
      ie_q          <= 1'b1;
      exl_q         <= 1'b0;
      mask_q        <= '1;
      pend_q        <= '0;
      irq_q         <= '0;
      sepc_q        <= '0;
      scause_q      <= '0;
      tvec_q        <= TVEC_RST;
      dfault_q      <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      ie_q          <= ie_d;
      exl_q         <= exl_d;
      mask_q        <= mask_d;
      pend_q        <= pend_d;
      irq_q         <= irq_in;
      sepc_q        <= sepc_d;
      scause_q      <= scause_d;
      tvec_q        <= tvec_d;
      dfault_q      <= dfault_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin : csr_read
    csr_rdata = '0;
    case (csr_addr)
      A_STATUS: csr_rdata = {30'b0, exl_q, ie_q};
      A_MASK:   csr_rdata = 32'(mask_q);
      A_PEND:   csr_rdata = 32'(pend_q);
      A_SEPC:   csr_rdata = sepc_q;
      A_SCAUSE: csr_rdata = scause_q;
      A_TVEC:   csr_rdata = tvec_q;
      default:  csr_rdata = '0;
    endcase
  end

  assign redirect     = redirect_q;
  assign flush        = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign in_trap      = exl_q;
  assign double_fault = dfault_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed trap scenarios plus random traffic against a behavioural model.
module tb_trap_ctrl;

  localparam int unsigned N = 8;
  localparam int M_RUN = 0, M_ENTER = 1, M_HANDLER = 2, M_RETURN = 3;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] T1_TGT = 32'h0000_010C;
  localparam bit VECTORED = 1'b1;
`else
  localparam logic [31:0] T1_TGT = 32'h0000_0100;
  localparam bit VECTORED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_in;
  logic          ex_valid;
  logic [31:0]   ex_pc;
  logic          exc_valid;
  logic [4:0]    exc_code;
  logic          mret;
  logic          csr_we;
  logic [2:0]    csr_addr;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          flush;
  logic          in_trap;
  logic          double_fault;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  trap_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .exc_valid   (exc_valid),
    .exc_code    (exc_code),
    .mret        (mret),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush),
    .in_trap     (in_trap),
    .double_fault(double_fault)
  );

  // Behavioural model of the architectural state
  int           m_mode;
  bit           m_ie, m_exl, m_df, m_redir;
  logic [N-1:0] m_mask, m_pend, m_prev;
  logic [31:0]  m_sepc, m_scause, m_tvec, m_rpc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_ie = 1'b1; m_exl = 1'b0; m_df = 1'b0; m_redir = 1'b0;
    m_mask = '1; m_pend = '0; m_prev = '0;
    m_sepc = '0; m_scause = '0; m_tvec = 32'h0000_0100; m_rpc = '0;
  endtask

  function automatic logic [31:0] model_rdata(input logic [2:0] a);
    case (a)
      3'd0:    return {30'b0, m_exl, m_ie};
      3'd1:    return 32'(m_mask);
      3'd2:    return 32'(m_pend);
      3'd3:    return m_sepc;
      3'd4:    return m_scause;
      3'd5:    return m_tvec;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the architectural rules, using the inputs held this cycle
  task automatic model_step();
    logic [N-1:0] rise, elig, taken;
    int idx;
    bit old_exl;
    rise    = irq_in & ~m_prev;
    m_prev  = irq_in;
    elig    = (m_ie && !m_exl) ? (m_pend & m_mask) : '0;
    old_exl = m_exl;
    taken   = '0;
    if (csr_we) begin
      case (csr_addr)
        3'd0: begin m_ie = csr_wdata[0]; m_exl = csr_wdata[1]; end
        3'd1: m_mask = csr_wdata[N-1:0];
        3'd2: m_pend = m_pend & ~csr_wdata[N-1:0];
        3'd3: m_sepc = csr_wdata & ~32'h3;
        3'd4: m_scause = csr_wdata;
        3'd5: m_tvec = csr_wdata & ~32'h3;
        default: ;
      endcase
    end
    m_redir = 1'b0;
    m_rpc   = '0;
    case (m_mode)
      M_RUN: begin
        if (ex_valid && (exc_valid || elig != 0)) begin
          m_sepc  = ex_pc;
          m_exl   = 1'b1;
          m_redir = 1'b1;
          m_mode  = M_ENTER;
          if (exc_valid) begin
            m_scause = 32'(exc_code);
            m_rpc    = m_tvec;
            if (old_exl) m_df = 1'b1;
          end else begin
            idx = 0;
            while (!elig[idx]) idx++;
            m_scause   = 32'h8000_0000 + 32'(idx);
            taken[idx] = 1'b1;
            m_rpc      = VECTORED ? m_tvec + 32'(4 * idx) : m_tvec;
          end
        end
      end
      M_ENTER: m_mode = M_HANDLER;
      M_HANDLER: begin
        if (ex_valid && exc_valid) begin
          m_df = 1'b1;
        end else if (ex_valid && mret) begin
          m_exl   = 1'b0;
          m_mode  = M_RETURN;
          m_redir = 1'b1;
          m_rpc   = m_sepc;
        end
      end
      default: m_mode = M_RUN;
    endcase
    m_pend = (m_pend & ~taken) | rise;
  endtask

  // Called at posedge+1; returns at the next posedge+1
  task automatic step();
    #2;
    check("csr_rdata", csr_rdata, model_rdata(csr_addr));
    @(posedge clk);
    model_step();
    #1;
    check("redirect", 32'(redirect), 32'(m_redir));
    check("flush", 32'(flush), 32'(m_redir));
    if (m_redir) check("redirect_pc", redirect_pc, m_rpc);
    check("in_trap", 32'(in_trap), 32'(m_exl));
    check("double_fault", 32'(double_fault), 32'(m_df));
  endtask

  task automatic read_csr(input logic [2:0] a, input logic [31:0] exp, input string tag);
    csr_addr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic idle();
    ex_valid = 1'b0; exc_valid = 1'b0; exc_code = '0; mret = 1'b0;
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0; ex_pc = '0;
  endtask

  task automatic check_reset_csrs(input string pfx);
    read_csr(3'd0, 32'h1, {pfx, "_status"});
    read_csr(3'd1, 32'hFF, {pfx, "_mask"});
    read_csr(3'd2, 32'h0, {pfx, "_pend"});
    read_csr(3'd3, 32'h0, {pfx, "_sepc"});
    read_csr(3'd4, 32'h0, {pfx, "_scause"});
    read_csr(3'd5, 32'h100, {pfx, "_tvec"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; irq_in = '0; idle(); model_reset();
    #3;
    check("rst_redirect", 32'(redirect), 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_csrs("rst");

    // Interrupt 3 taken from RUN
    irq_in = 8'h08; ex_valid = 1'b1; ex_pc = 32'h40;
    step(); step();
    check("t1_redirect", 32'(redirect), 32'h1);
    check("t1_target", redirect_pc, T1_TGT);
    read_csr(3'd3, 32'h40, "t1_sepc");
    read_csr(3'd4, 32'h8000_0003, "t1_scause");
    idle(); step();
    ex_valid = 1'b1; mret = 1'b1; step();
    check("t1_ret_pc", redirect_pc, 32'h40);
    idle(); step();

    // Exception beats a same-cycle interrupt edge; interrupt follows after mret
    ex_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd2; ex_pc = 32'h80; irq_in = 8'h09;
    step();
    read_csr(3'd4, 32'h2, "t2_scause");
    read_csr(3'd2, 32'h1, "t2_pend");
    idle(); step();
    ex_valid = 1'b1; mret = 1'b1; step();
    mret = 1'b0; ex_pc = 32'h84; step();
    check("t2_ret_quiet", 32'(redirect), 32'h0);
    step();
    check("t2_irq_taken", 32'(redirect), 32'h1);
    read_csr(3'd4, 32'h8000_0000, "t2_irq_scause");
    idle(); step();
    ex_valid = 1'b1; mret = 1'b1; step();
    idle(); step();

    // Masked interrupt stays pending until MASK opens
    irq_in = 8'h08; csr_we = 1'b1; csr_addr = 3'd1; csr_wdata = 32'hFE; step();
    csr_we = 1'b0; irq_in = 8'h09; ex_valid = 1'b1; ex_pc = 32'h200;
    step(); step(); step();
    check("t3_masked", 32'(redirect), 32'h0);
    read_csr(3'd2, 32'h1, "t3_pend");
    csr_we = 1'b1; csr_addr = 3'd1; csr_wdata = 32'hFF; step();
    csr_we = 1'b0; step();
    check("t3_taken", 32'(redirect), 32'h1);
    read_csr(3'd4, 32'h8000_0000, "t3_scause");
    idle(); step();

    // Exception inside handler
    ex_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd5; ex_pc = 32'h300; step();
    check("t4_dfault", 32'(double_fault), 32'h1);
    read_csr(3'd3, 32'h200, "t4_sepc");
    read_csr(3'd4, 32'h8000_0000, "t4_scause");
    exc_valid = 1'b0; mret = 1'b1; step();
    check("t4_ret_pc", redirect_pc, 32'h200);
    check("t4_in_trap", 32'(in_trap), 32'h0);
    idle(); step();

    // Bubbles hold off the trap
    irq_in = 8'h29; step(); step(); step();
    check("t5_bubble", 32'(redirect), 32'h0);
    ex_valid = 1'b1; ex_pc = 32'h500; step();
    check("t5_taken", 32'(redirect), 32'h1);
    read_csr(3'd4, 32'h8000_0005, "t5_scause");
    idle(); step();
    ex_valid = 1'b1; mret = 1'b1; step();
    idle(); step();

    // Reset in the middle of ENTER
    irq_in = 8'h2B; ex_valid = 1'b1; ex_pc = 32'h600; step(); step();
    check("t6_enter", 32'(redirect), 32'h1);
    #3; reset = 1'b1; #1;
    check("t6_redirect", 32'(redirect), 32'h0);
    check("t6_flush", 32'(flush), 32'h0);
    check("t6_redirect_pc", redirect_pc, 32'h0);
    check("t6_in_trap", 32'(in_trap), 32'h0);
    check("t6_dfault", 32'(double_fault), 32'h0);
    idle(); model_reset();
    check_reset_csrs("t6");
    @(posedge clk); #1;
    reset = 1'b0; irq_in = '0;

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int b;
        b = int'($urandom_range(0, N - 1));
        irq_in[b] = ~irq_in[b];
      end
      ex_valid  = ($urandom_range(0, 3) != 0);
      exc_valid = ($urandom_range(0, 11) == 0);
      exc_code  = 5'($urandom);
      mret      = ($urandom_range(0, 4) == 0);
      ex_pc     = 32'($urandom) & ~32'h3;
      csr_we    = ($urandom_range(0, 9) == 0);
      csr_addr  = csr_we ? 3'($urandom_range(1, 5)) : 3'($urandom_range(0, 7));
      csr_wdata = 32'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
